// File: rtl/sdram_port_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_port_mux_if                                                          |
// | Kvaz, auxiliary byte port and SDRAM controller request signals.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sdram_port_mux_if;
  logic        kvaz_rd;
  logic        kvaz_wr;
  logic [21:0] kvaz_addr;
  logic        kvaz_lb;
  logic        kvaz_ub;
  logic [15:0] kvaz_wdata;
  logic        aux_push;
  logic        aux_we;
  logic [22:0] aux_addr;
  logic [7:0]  aux_wdata;
  logic        aux_full;
  logic [7:0]  aux_rdata;
  logic        aux_rvalid;
  logic        aux_wdone;
  logic        slot;
  logic        membusy;
  logic [15:0] datar;
  logic        sd_rd;
  logic        sd_we_n;
  logic [21:0] sd_addr;
  logic [15:0] sd_dataw;
  logic        sd_lb_n;
  logic        sd_ub_n;
  logic        collision;

  modport slave (
    input  kvaz_rd, kvaz_wr, kvaz_addr, kvaz_lb, kvaz_ub, kvaz_wdata,
    input  aux_push, aux_we, aux_addr, aux_wdata, slot, membusy, datar,
    output aux_full, aux_rdata, aux_rvalid, aux_wdone,
    output sd_rd, sd_we_n, sd_addr, sd_dataw, sd_lb_n, sd_ub_n, collision
  );

  modport master (
    output kvaz_rd, kvaz_wr, kvaz_addr, kvaz_lb, kvaz_ub, kvaz_wdata,
    output aux_push, aux_we, aux_addr, aux_wdata, slot, membusy, datar,
    input  aux_full, aux_rdata, aux_rvalid, aux_wdone,
    input  sd_rd, sd_we_n, sd_addr, sd_dataw, sd_lb_n, sd_ub_n, collision
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_port_mux                                                             |
// | Kvaz-priority SDRAM front end; aux byte requests use free refresh slots.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sdram_port_mux #(
  parameter int FIFO_AW  = 2,
  parameter int WAIT_MAX = 7
) (
  input  logic             clk_cpu,
  input  logic             sys_reset,
  sdram_port_mux_if.slave  bus
);
  localparam int c_DEPTH = 1 << FIFO_AW;
  localparam int c_PW    = FIFO_AW + 1;
  localparam int c_CW    = $clog2(WAIT_MAX + 2);

  localparam logic [2:0] c_S_IDLE       = 3'd0;
  localparam logic [2:0] c_S_KVAZ       = 3'd1;
  localparam logic [2:0] c_S_AUX_CMD    = 3'd2;
  localparam logic [2:0] c_S_AUX_WAITHI = 3'd3;
  localparam logic [2:0] c_S_AUX_WAITLO = 3'd4;
  localparam logic [2:0] c_S_KVAZ_PEND  = 3'd5;

  logic [31:0]     r_mem [c_DEPTH];
  logic [c_PW-1:0] r_wptr, r_rptr;
  logic [2:0]      r_state, w_state_nxt;
  logic [c_CW-1:0] r_wait;
  logic            r_cmd_we, r_cmd_a0;
  logic            r_pend;
  // Command vector: {rd, wr, lb, ub, addr[21:0], data[15:0]}
  logic [41:0]     r_pend_cmd, w_live_cmd, w_aux_cmd, w_cmd;
  logic [31:0]     w_head;
  logic            w_empty, w_full, w_push, w_pop, w_kreq, w_timeout;
  logic            w_load, w_complete, w_latch, w_pend_clr, w_aux_busy;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                    (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_push   = bus.aux_push && !w_full;
  assign w_head   = r_mem[r_rptr[FIFO_AW-1:0]];
  assign w_kreq   = bus.kvaz_rd || bus.kvaz_wr;
  assign w_timeout = (r_wait >= c_CW'(WAIT_MAX));
  assign w_aux_busy = (r_state == c_S_AUX_CMD) || (r_state == c_S_AUX_WAITHI) ||
                      (r_state == c_S_AUX_WAITLO);
  assign bus.aux_full = w_full;

  assign w_live_cmd = {bus.kvaz_rd, bus.kvaz_wr, bus.kvaz_lb, bus.kvaz_ub,
                       bus.kvaz_addr, bus.kvaz_wdata};
  // addr[0]=1 is the low byte of the 16-bit word
  assign w_aux_cmd  = {~w_head[31], w_head[31], w_head[8], ~w_head[8],
                       w_head[30:9], w_head[7:0], w_head[7:0]};

  always_ff @(posedge clk_cpu) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= {bus.aux_we, bus.aux_addr, bus.aux_wdata};
  end

  always_ff @(posedge clk_cpu or posedge sys_reset) begin
    if (sys_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cmd       = w_live_cmd;
    w_pop       = 1'b0;
    w_complete  = 1'b0;
    w_latch     = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (w_kreq) begin
          w_load      = 1'b1;
          w_state_nxt = c_S_KVAZ;
        end else if (r_pend) begin
          w_load      = 1'b1;
          w_cmd       = r_pend_cmd;
          w_pend_clr  = 1'b1;
          w_state_nxt = c_S_KVAZ_PEND;
        end else if (bus.slot && !w_empty) begin
          w_load      = 1'b1;
          w_cmd       = w_aux_cmd;
          w_pop       = 1'b1;
          w_state_nxt = c_S_AUX_CMD;
        end
      end
      c_S_KVAZ, c_S_KVAZ_PEND: begin
        w_latch     = w_kreq;
        w_state_nxt = c_S_IDLE;
      end
      c_S_AUX_CMD: begin
        w_latch     = w_kreq;
        w_state_nxt = c_S_AUX_WAITHI;
      end
      c_S_AUX_WAITHI: begin
        w_latch = w_kreq;
        if (bus.membusy)    w_state_nxt = c_S_AUX_WAITLO;
        else if (w_timeout) w_complete  = 1'b1;
      end
      c_S_AUX_WAITLO: begin
        w_latch = w_kreq;
        if (!bus.membusy) w_complete = 1'b1;
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
    // A request arriving on the completion cycle goes straight out instead of via the latch
    if (w_complete) begin
      if (w_kreq) begin
        w_load      = 1'b1;
        w_latch     = 1'b0;
        w_state_nxt = c_S_KVAZ_PEND;
      end else if (r_pend) begin
        w_load      = 1'b1;
        w_cmd       = r_pend_cmd;
        w_pend_clr  = 1'b1;
        w_state_nxt = c_S_KVAZ_PEND;
      end else begin
        w_state_nxt = c_S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_cpu or posedge sys_reset) begin
    if (sys_reset) begin
      r_state        <= c_S_IDLE;
      r_wait         <= '0;
      r_cmd_we       <= 1'b0;
      r_cmd_a0       <= 1'b0;
      r_pend         <= 1'b0;
      r_pend_cmd     <= '0;
      bus.sd_rd      <= 1'b0;
      bus.sd_we_n    <= 1'b1;
      bus.sd_addr    <= '0;
      bus.sd_dataw   <= '0;
      bus.sd_lb_n    <= 1'b1;
      bus.sd_ub_n    <= 1'b1;
      bus.aux_rdata  <= '0;
      bus.aux_rvalid <= 1'b0;
      bus.aux_wdone  <= 1'b0;
      bus.collision  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      bus.aux_rvalid <= 1'b0;
      bus.aux_wdone  <= 1'b0;
      if (w_load) begin
        bus.sd_rd    <= w_cmd[41];
        bus.sd_we_n  <= ~w_cmd[40];
        bus.sd_lb_n  <= ~w_cmd[39];
        bus.sd_ub_n  <= ~w_cmd[38];
        bus.sd_addr  <= w_cmd[37:16];
        bus.sd_dataw <= w_cmd[15:0];
      end else begin
        bus.sd_rd    <= 1'b0;
        bus.sd_we_n  <= 1'b1;
        bus.sd_lb_n  <= 1'b1;
        bus.sd_ub_n  <= 1'b1;
      end
      // Counter starts on the command cycle so the timeout lands WAIT_MAX+1 cycles later
      if (w_pop) begin
        r_cmd_we <= w_head[31];
        r_cmd_a0 <= w_head[8];
        r_wait   <= '0;
      end else if ((r_state == c_S_AUX_CMD) ||
                   ((r_state == c_S_AUX_WAITHI) && !w_timeout)) begin
        r_wait <= r_wait + c_CW'(1);
      end
      if (w_complete) begin
        if (r_cmd_we) begin
          bus.aux_wdone <= 1'b1;
        end else begin
          bus.aux_rvalid <= 1'b1;
          bus.aux_rdata  <= r_cmd_a0 ? bus.datar[7:0] : bus.datar[15:8];
        end
      end
      if (w_latch) begin
        r_pend     <= 1'b1;
        r_pend_cmd <= w_live_cmd;
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
      if (w_kreq && w_aux_busy) bus.collision <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sdram_port_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdram_port_mux                                                          |
// | Directed bench for the kvaz/aux SDRAM port multiplexer.                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sdram_port_mux;
  logic clk_cpu = 1'b0;
  logic sys_reset;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  sdram_port_mux_if bus();

  sdram_port_mux #(.FIFO_AW(2), .WAIT_MAX(7)) dut (
    .clk_cpu   (clk_cpu),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic push(input logic we, input logic [22:0] addr, input logic [7:0] data);
    bus.aux_push  = 1'b1;
    bus.aux_we    = we;
    bus.aux_addr  = addr;
    bus.aux_wdata = data;
    tick();
    bus.aux_push  = 1'b0;
  endtask

  task automatic give_slot();
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
  endtask

  logic [21:0] exp_addr [4];
  logic [15:0] exp_data [4];

  initial begin
    exp_addr[0] = 22'h08; exp_data[0] = 16'h1111;
    exp_addr[1] = 22'h09; exp_data[1] = 16'h2222;
    exp_addr[2] = 22'h0A; exp_data[2] = 16'h3333;
    exp_addr[3] = 22'h0B; exp_data[3] = 16'h4444;

    sys_reset      = 1'b1;
    bus.kvaz_rd    = 1'b0;
    bus.kvaz_wr    = 1'b0;
    bus.kvaz_addr  = '0;
    bus.kvaz_lb    = 1'b0;
    bus.kvaz_ub    = 1'b0;
    bus.kvaz_wdata = '0;
    bus.aux_push   = 1'b0;
    bus.aux_we     = 1'b0;
    bus.aux_addr   = '0;
    bus.aux_wdata  = '0;
    bus.slot       = 1'b0;
    bus.membusy    = 1'b0;
    bus.datar      = '0;
    repeat (3) tick();
    sys_reset = 1'b0;
    tick();

    // Reset values
    chk("rst_sd_rd",   bus.sd_rd,      32'h0);
    chk("rst_sd_we_n", bus.sd_we_n,    32'h1);
    chk("rst_lb_n",    bus.sd_lb_n,    32'h1);
    chk("rst_ub_n",    bus.sd_ub_n,    32'h1);
    chk("rst_addr",    bus.sd_addr,    32'h0);
    chk("rst_dataw",   bus.sd_dataw,   32'h0);
    chk("rst_full",    bus.aux_full,   32'h0);
    chk("rst_rvalid",  bus.aux_rvalid, 32'h0);
    chk("rst_wdone",   bus.aux_wdone,  32'h0);
    chk("rst_rdata",   bus.aux_rdata,  32'h0);
    chk("rst_coll",    bus.collision,  32'h0);

    // Kvaz write
    bus.kvaz_wr = 1'b1; bus.kvaz_addr = 22'h012345; bus.kvaz_lb = 1'b1;
    bus.kvaz_ub = 1'b0; bus.kvaz_wdata = 16'hA5A5;
    tick();
    bus.kvaz_wr = 1'b0;
    chk("kw_we_n",  bus.sd_we_n,  32'h0);
    chk("kw_rd",    bus.sd_rd,    32'h0);
    chk("kw_addr",  bus.sd_addr,  32'h012345);
    chk("kw_lb_n",  bus.sd_lb_n,  32'h0);
    chk("kw_ub_n",  bus.sd_ub_n,  32'h1);
    chk("kw_dataw", bus.sd_dataw, 32'hA5A5);
    tick();
    chk("kw_we_n_after", bus.sd_we_n, 32'h1);

    // Aux write then read of byte address 3
    push(1'b1, 23'h000003, 8'h5A);
    push(1'b0, 23'h000003, 8'h00);
    give_slot();
    chk("aw_we_n",  bus.sd_we_n,  32'h0);
    chk("aw_rd",    bus.sd_rd,    32'h0);
    chk("aw_addr",  bus.sd_addr,  32'h000001);
    chk("aw_dataw", bus.sd_dataw, 32'h5A5A);
    chk("aw_lb_n",  bus.sd_lb_n,  32'h0);
    chk("aw_ub_n",  bus.sd_ub_n,  32'h1);
    bus.membusy = 1'b1;
    tick();
    tick();
    bus.membusy = 1'b0;
    chk("aw_wdone_early", bus.aux_wdone, 32'h0);
    tick();
    chk("aw_wdone",  bus.aux_wdone,  32'h1);
    chk("aw_rvalid", bus.aux_rvalid, 32'h0);
    tick();
    chk("aw_wdone_end", bus.aux_wdone, 32'h0);
    bus.datar = 16'h005A;
    give_slot();
    chk("ar_rd",   bus.sd_rd,   32'h1);
    chk("ar_we_n", bus.sd_we_n, 32'h1);
    chk("ar_addr", bus.sd_addr, 32'h000001);
    bus.membusy = 1'b1;
    tick();
    tick();
    bus.membusy = 1'b0;
    tick();
    chk("ar_rvalid", bus.aux_rvalid, 32'h1);
    chk("ar_rdata",  bus.aux_rdata,  32'h5A);
    tick();
    chk("ar_rvalid_end", bus.aux_rvalid, 32'h0);

    // Full and pointer wrap; completions by timeout
    push(1'b1, 23'h10, 8'h11);
    push(1'b1, 23'h12, 8'h22);
    push(1'b1, 23'h14, 8'h33);
    chk("full_3", bus.aux_full, 32'h0);
    push(1'b1, 23'h16, 8'h44);
    chk("full_4", bus.aux_full, 32'h1);
    push(1'b1, 23'h18, 8'h55);
    chk("full_5", bus.aux_full, 32'h1);
    for (int i = 0; i < 4; i++) begin
      give_slot();
      chk("drain_we_n",  bus.sd_we_n,  32'h0);
      chk("drain_addr",  bus.sd_addr,  {10'h0, exp_addr[i]});
      chk("drain_dataw", bus.sd_dataw, {16'h0, exp_data[i]});
      chk("drain_ub_n",  bus.sd_ub_n,  32'h0);
      repeat (7) tick();
      chk("tmo_wdone_early", bus.aux_wdone, 32'h0);
      tick();
      chk("tmo_wdone", bus.aux_wdone, 32'h1);
    end
    chk("drain_full", bus.aux_full, 32'h0);
    give_slot();
    chk("drain_dropped_we_n", bus.sd_we_n, 32'h1);
    chk("drain_dropped_rd",   bus.sd_rd,   32'h0);

    // Kvaz read and slot together: kvaz wins, FIFO untouched
    push(1'b0, 23'h20, 8'h00);
    bus.kvaz_rd = 1'b1; bus.kvaz_addr = 22'h0ABCDE; bus.kvaz_lb = 1'b1; bus.kvaz_ub = 1'b1;
    bus.slot = 1'b1;
    tick();
    bus.kvaz_rd = 1'b0; bus.slot = 1'b0;
    chk("sim_rd",   bus.sd_rd,   32'h1);
    chk("sim_we_n", bus.sd_we_n, 32'h1);
    chk("sim_addr", bus.sd_addr, 32'h0ABCDE);
    tick();
    chk("sim_rd_after", bus.sd_rd, 32'h0);
    bus.datar = 16'hC35A;
    give_slot();
    chk("sim_aux_rd",   bus.sd_rd,   32'h1);
    chk("sim_aux_addr", bus.sd_addr, 32'h10);
    repeat (8) tick();
    chk("sim_rvalid", bus.aux_rvalid, 32'h1);
    chk("sim_rdata",  bus.aux_rdata,  32'hC3);

    // Kvaz write during AUX_WAITLO
    push(1'b1, 23'h41, 8'h77);
    give_slot();
    chk("col_aux_addr",  bus.sd_addr,  32'h20);
    chk("col_aux_dataw", bus.sd_dataw, 32'h7777);
    bus.membusy = 1'b1;
    tick();
    tick();
    bus.kvaz_wr = 1'b1; bus.kvaz_addr = 22'h000777; bus.kvaz_lb = 1'b1;
    bus.kvaz_ub = 1'b1; bus.kvaz_wdata = 16'hBEEF;
    tick();
    bus.kvaz_wr = 1'b0;
    chk("col_flag",  bus.collision, 32'h1);
    chk("col_held",  bus.sd_we_n,   32'h1);
    bus.membusy = 1'b0;
    tick();
    chk("col_wdone", bus.aux_wdone, 32'h1);
    chk("col_we_n",  bus.sd_we_n,   32'h0);
    chk("col_addr",  bus.sd_addr,   32'h000777);
    chk("col_dataw", bus.sd_dataw,  32'hBEEF);
    chk("col_lb_n",  bus.sd_lb_n,   32'h0);
    chk("col_ub_n",  bus.sd_ub_n,   32'h0);
    tick();
    chk("col_we_n_after", bus.sd_we_n,   32'h1);
    chk("col_sticky",     bus.collision, 32'h1);

    // Reset during AUX_WAITLO
    push(1'b0, 23'h01, 8'h00);
    push(1'b0, 23'h02, 8'h00);
    give_slot();
    chk("rr_rd", bus.sd_rd, 32'h1);
    bus.membusy = 1'b1;
    tick();
    tick();
    sys_reset = 1'b1;
    #1;
    chk("rr_async_coll", bus.collision, 32'h0);
    bus.membusy = 1'b0;
    tick();
    chk("rr_we_n",   bus.sd_we_n,    32'h1);
    chk("rr_sd_rd",  bus.sd_rd,      32'h0);
    chk("rr_rvalid", bus.aux_rvalid, 32'h0);
    chk("rr_full",   bus.aux_full,   32'h0);
    sys_reset = 1'b0;
    tick();
    chk("rr_rvalid_post", bus.aux_rvalid, 32'h0);
    give_slot();
    chk("rr_flushed", bus.sd_rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
